// File: rtl/disp_sched.sv
// disp_sched: display scheduler for a four-digit alarm clock tube display.
// Chooses time or alarm digits, drives per-digit blink masks while a field
// is being adjusted, and runs the alarm ring with key dismiss and timeout.
//
// Handshake note: there is no valid/ready flow here. Every input is a level
// or a single-cycle pulse that is sampled on each clk edge. Every output is
// registered. The output registers take their values from the state that the
// FSM is moving into, so a mode change appears on the outputs at the same
// edge that makes it.
module disp_sched #(
  parameter int BLINK_HALF = 250,
  parameter int RING_SEC   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1k,
  input  logic       sw0,
  input  logic       sw1,
  input  logic       key_sel,
  input  logic       alarm_hit,
  input  logic [3:0] t_hourH,
  input  logic [3:0] t_hourL,
  input  logic [3:0] t_minH,
  input  logic [3:0] t_minL,
  input  logic [3:0] a_hourH,
  input  logic [3:0] a_hourL,
  input  logic [3:0] a_minH,
  input  logic [3:0] a_minL,
  output logic [3:0] dig3,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [3:0] blank,
  output logic [1:0] adj_field,
  output logic       adj_tgt,
  output logic       ring
);

  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int SECW = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_RING     = 2'd1,
    S_ADJ_MIN  = 2'd2,
    S_ADJ_HOUR = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_sw0_q;
  logic            r_sw1_q;
  logic [BW-1:0]   r_blink_cnt;
  logic [BW-1:0]   w_blink_cnt_next;
  logic            r_blink_ph;
  logic            w_blink_ph_next;
  logic [9:0]      r_ms;
  logic [SECW-1:0] r_sec;
  logic            w_ring_expire;
  logic            w_show_time;
  logic [3:0]      w_blank_next;
  logic [3:0]      r_dig3, r_dig2, r_dig1, r_dig0;
  logic [3:0]      r_blank;
  logic [1:0]      r_adj_field;
  logic            r_adj_tgt;
  logic            r_ring;

  // Switch synchronisers: every decision in this block uses only these copies.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw0_q <= 1'b0;
      r_sw1_q <= 1'b0;
    end else begin
      r_sw0_q <= sw0;
      r_sw1_q <= sw1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_next;
  end

  // Next state. Leaving auto mode beats everything; in RUN an alarm beats a key.
  always_comb begin
    w_state_next  = r_state;
    w_ring_expire = (r_state == S_RING) && tick_1k && (r_ms == 10'd999) &&
                    (r_sec == SECW'(RING_SEC - 1));
    case (r_state)
      S_RUN: begin
        if (!r_sw0_q)       w_state_next = S_ADJ_MIN;
        else if (alarm_hit) w_state_next = S_RING;
      end
      S_RING: begin
        if (!r_sw0_q)                     w_state_next = S_ADJ_MIN;
        else if (key_sel || w_ring_expire) w_state_next = S_RUN;
      end
      S_ADJ_MIN: begin
        if (r_sw0_q)      w_state_next = S_RUN;
        else if (key_sel) w_state_next = S_ADJ_HOUR;
      end
      S_ADJ_HOUR: begin
        if (r_sw0_q)      w_state_next = S_RUN;
        else if (key_sel) w_state_next = S_ADJ_MIN;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  // Blink phase. A state change restarts it so the new field is visible first.
  always_comb begin
    w_blink_cnt_next = r_blink_cnt;
    w_blink_ph_next  = r_blink_ph;
    if (w_state_next != r_state) begin
      w_blink_cnt_next = '0;
      w_blink_ph_next  = 1'b0;
    end else if (tick_1k) begin
      if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
        w_blink_cnt_next = '0;
        w_blink_ph_next  = ~r_blink_ph;
      end else begin
        w_blink_cnt_next = r_blink_cnt + 1'b1;
      end
    end
  end

  // Blink counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_ph  <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_cnt_next;
      r_blink_ph  <= w_blink_ph_next;
    end
  end

  // Ring timer: ms/sec counters cleared on RING entry and advanced only while ringing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ms  <= '0;
      r_sec <= '0;
    end else if ((w_state_next == S_RING) && (r_state != S_RING)) begin
      r_ms  <= '0;
      r_sec <= '0;
    end else if ((r_state == S_RING) && tick_1k) begin
      if (r_ms == 10'd999) begin
        r_ms <= '0;
        if (r_sec == SECW'(RING_SEC - 1)) r_sec <= '0;
        else                              r_sec <= r_sec + 1'b1;
      end else begin
        r_ms <= r_ms + 10'd1;
      end
    end
  end

  // Digit source and blank mask for the state being entered.
  always_comb begin
    w_show_time  = (w_state_next == S_RUN) || (w_state_next == S_RING) || r_sw1_q;
    w_blank_next = 4'b0000;
    case (w_state_next)
      S_RING:     w_blank_next = {4{w_blink_ph_next}};
      S_ADJ_MIN:  w_blank_next = {2'b00, w_blink_ph_next, w_blink_ph_next};
      S_ADJ_HOUR: w_blank_next = {w_blink_ph_next, w_blink_ph_next, 2'b00};
      default:    w_blank_next = 4'b0000;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dig3      <= 4'd0;
      r_dig2      <= 4'd0;
      r_dig1      <= 4'd0;
      r_dig0      <= 4'd0;
      r_blank     <= 4'b0000;
      r_adj_field <= 2'b00;
      r_adj_tgt   <= 1'b1;
      r_ring      <= 1'b0;
    end else begin
      r_dig3      <= w_show_time ? t_hourH : a_hourH;
      r_dig2      <= w_show_time ? t_hourL : a_hourL;
      r_dig1      <= w_show_time ? t_minH  : a_minH;
      r_dig0      <= w_show_time ? t_minL  : a_minL;
      r_blank     <= w_blank_next;
      r_adj_field <= (w_state_next == S_ADJ_MIN)  ? 2'b01 :
                     (w_state_next == S_ADJ_HOUR) ? 2'b10 : 2'b00;
      r_adj_tgt   <= ((w_state_next == S_ADJ_MIN) || (w_state_next == S_ADJ_HOUR)) ?
                     r_sw1_q : 1'b1;
      r_ring      <= (w_state_next == S_RING);
    end
  end

  assign dig3      = r_dig3;
  assign dig2      = r_dig2;
  assign dig1      = r_dig1;
  assign dig0      = r_dig0;
  assign blank     = r_blank;
  assign adj_field = r_adj_field;
  assign adj_tgt   = r_adj_tgt;
  assign ring      = r_ring;

endmodule

// File: tb/tb_disp_sched.sv
// tb_disp_sched: directed scenarios plus a randomized phase, with a
// behavioural model whose expected outputs are queued and compared every cycle.
module tb_disp_sched;

  localparam int BH = 250;
  localparam int RS = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1k = 1'b0;
  logic       sw0 = 1'b0;
  logic       sw1 = 1'b0;
  logic       key_sel = 1'b0;
  logic       alarm_hit = 1'b0;
  logic [3:0] t_hourH = 4'd0, t_hourL = 4'd0, t_minH = 4'd0, t_minL = 4'd0;
  logic [3:0] a_hourH = 4'd0, a_hourL = 4'd0, a_minH = 4'd0, a_minL = 4'd0;
  logic [3:0] dig3, dig2, dig1, dig0, blank;
  logic [1:0] adj_field;
  logic       adj_tgt, ring;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  disp_sched #(.BLINK_HALF(BH), .RING_SEC(RS)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1k(tick_1k), .sw0(sw0), .sw1(sw1),
    .key_sel(key_sel), .alarm_hit(alarm_hit),
    .t_hourH(t_hourH), .t_hourL(t_hourL), .t_minH(t_minH), .t_minL(t_minL),
    .a_hourH(a_hourH), .a_hourL(a_hourL), .a_minH(a_minH), .a_minL(a_minL),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0), .blank(blank),
    .adj_field(adj_field), .adj_tgt(adj_tgt), .ring(ring)
  );

  // Clock.
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Modes: 0 = run, 1 = ringing, 2 = adjusting minutes, 3 = adjusting hours.
  // m_ticks counts tick_1k pulses since the current mode was entered; the blink
  // phase is which half-period that count falls in, and the ring lasts RS*1000 ticks.
  int          m_mode = 0;
  int          m_ticks = 0;
  bit          m_sw0q = 1'b0;
  bit          m_sw1q = 1'b0;
  logic [23:0] exp_q[$];

  always @(posedge clk) begin
    int          nm;
    bit          ph;
    logic [15:0] d;
    logic [3:0]  bl;
    logic [1:0]  af;
    logic [23:0] e;
    if (!rst_n) begin
      m_mode  = 0;
      m_ticks = 0;
      e       = {16'h0000, 4'b0000, 2'b00, 1'b1, 1'b0};
      m_sw0q  = 1'b0;
      m_sw1q  = 1'b0;
    end else begin
      nm = m_mode;
      if (m_mode <= 1 && !m_sw0q) nm = 2;
      else if (m_mode == 0 && alarm_hit) nm = 1;
      else if (m_mode == 1 && (key_sel || (tick_1k && m_ticks + 1 == RS * 1000))) nm = 0;
      else if (m_mode >= 2 && m_sw0q) nm = 0;
      else if (m_mode >= 2 && key_sel) nm = 5 - m_mode;
      if (nm != m_mode) m_ticks = 0;
      else if (tick_1k) m_ticks = m_ticks + 1;
      ph = ((m_ticks / BH) % 2) == 1;
      d  = (nm <= 1 || m_sw1q) ? {t_hourH, t_hourL, t_minH, t_minL}
                                : {a_hourH, a_hourL, a_minH, a_minL};
      bl = (nm == 1) ? {4{ph}} : (nm == 2) ? {2'b00, ph, ph} :
           (nm == 3) ? {ph, ph, 2'b00} : 4'b0000;
      af = (nm == 2) ? 2'b01 : (nm == 3) ? 2'b10 : 2'b00;
      e  = {d, bl, af, (nm >= 2) ? m_sw1q : 1'b1, (nm == 1)};
      m_mode = nm;
      m_sw0q = sw0;
      m_sw1q = sw1;
    end
    exp_q.push_back(e);
  end

  // Scoreboard: compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [23:0] e;
    logic [23:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {dig3, dig2, dig1, dig0, blank, adj_field, adj_tgt, ring};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        if (n_print < 40) begin
          n_print++;
          $display("FAIL outputs t=%0t actual=%h expected=%h (dig[23:8] blank[7:4] field[3:2] tgt[1] ring[0])",
                   $time, a, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick_1k = 1'b1;
      @(negedge clk);
      tick_1k = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_key();
    key_sel = 1'b1;
    @(negedge clk);
    key_sel = 1'b0;
  endtask

  task automatic pulse_alarm();
    alarm_hit = 1'b1;
    @(negedge clk);
    alarm_hit = 1'b0;
  endtask

  // Watchdog: the run must end on its own.
  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    {t_hourH, t_hourL, t_minH, t_minL} = 16'h1234;
    {a_hourH, a_hourL, a_minH, a_minL} = 16'h0705;
    sw0 = 1'b1;
    sw1 = 1'b0;
    rst_n = 1'b0;
    cyc(2);
    chk("reset_outputs", {dig3, dig2, dig1, dig0, blank, adj_field, adj_tgt, ring}, 24'h000002);

    // Reset then run: time shown once the registered sw0 reaches auto mode.
    rst_n = 1'b1;
    cyc(3);
    chk("run_digits", {dig3, dig2, dig1, dig0}, 16'h1234);
    chk("run_blank", blank, 4'b0000);
    chk("run_ring", ring, 1'b0);

    // Adjust time, minutes field blinking.
    sw0 = 1'b0;
    sw1 = 1'b1;
    cyc(2);
    chk("adj_field_min", adj_field, 2'b01);
    chk("adj_tgt_time", adj_tgt, 1'b1);
    tick_n(249);
    chk("blink_249", blank, 4'b0000);
    tick_n(1);
    chk("blink_250", blank, 4'b0011);
    tick_n(250);
    chk("blink_500", blank, 4'b0000);
    pulse_key();
    chk("adj_field_hour", adj_field, 2'b10);
    chk("blank_restart", blank, 4'b0000);
    tick_n(250);
    chk("blink_hour", blank, 4'b1100);

    // Reset in the middle of hour adjust with the field blanked.
    rst_n = 1'b0;
    cyc(1);
    chk("midreset_outputs", {dig3, dig2, dig1, dig0, blank, adj_field, adj_tgt, ring}, 24'h000002);
    cyc(1);

    // Alarm view, then switch the target to time.
    sw0 = 1'b0;
    sw1 = 1'b0;
    rst_n = 1'b1;
    cyc(2);
    chk("alarm_digits", {dig3, dig2, dig1, dig0}, 16'h0705);
    chk("alarm_tgt", adj_tgt, 1'b0);
    sw1 = 1'b1;
    cyc(1);
    chk("sw1_lag1", {dig3, dig2, dig1, dig0}, 16'h0705);
    cyc(1);
    chk("sw1_lag2", {dig3, dig2, dig1, dig0}, 16'h1234);
    chk("sw1_tgt", adj_tgt, 1'b1);

    // Ring timeout.
    sw0 = 1'b1;
    cyc(3);
    chk("back_run_field", adj_field, 2'b00);
    pulse_alarm();
    chk("ring_on", ring, 1'b1);
    chk("ring_blank0", blank, 4'b0000);
    tick_1k = 1'b1;
    cnt = 0;
    while (ring && cnt < 31000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 249) chk("ring_blink_249", blank, 4'b0000);
      if (cnt == 250) chk("ring_blink_250", blank, 4'b1111);
      if (cnt == 500) chk("ring_blink_500", blank, 4'b0000);
    end
    tick_1k = 1'b0;
    chk("ring_length_ticks", cnt, 30000);

    // Alarm and key together: alarm wins; a later key dismisses.
    alarm_hit = 1'b1;
    key_sel = 1'b1;
    @(negedge clk);
    alarm_hit = 1'b0;
    key_sel = 1'b0;
    chk("alarm_over_key", ring, 1'b1);
    cyc(3);
    chk("still_ringing", ring, 1'b1);
    pulse_key();
    chk("key_dismiss", ring, 1'b0);

    // Leaving auto mode during a ring cancels it.
    pulse_alarm();
    chk("ring_again", ring, 1'b1);
    sw0 = 1'b0;
    cyc(1);
    chk("sw0_lag_ring", ring, 1'b1);
    cyc(1);
    chk("sw0_cancel_ring", ring, 1'b0);
    chk("sw0_cancel_field", adj_field, 2'b01);

    // Randomized phase, checked by the model every cycle.
    sw0 = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 199) == 0) sw0 = ~sw0;
      if ($urandom_range(0, 99) == 0) sw1 = ~sw1;
      key_sel   = ($urandom_range(0, 9) == 0);
      alarm_hit = ($urandom_range(0, 11) == 0);
      tick_1k   = ($urandom_range(0, 1) == 1);
      rst_n     = ($urandom_range(0, 999) != 0);
      {t_hourH, t_hourL, t_minH, t_minL} = 16'($urandom);
      {a_hourH, a_hourL, a_minH, a_minL} = 16'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b1;
    key_sel = 1'b0;
    alarm_hit = 1'b0;
    tick_1k = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 The block SHALL have a parameter BLINK_HALF, default 250, giving the blink half-period in tick_1k pulses.
REQ-002 The block SHALL have a parameter RING_SEC, default 30, giving the maximum alarm ring duration in seconds.
REQ-003 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  reset. Synchronous, active-low.
- tick_1k  in  1  1 kHz enable pulse, one clk wide.
- sw0  in  1  1 = auto timekeeping, 0 = manual adjust.
- sw1  in  1  in adjust: 1 = adjust time, 0 = adjust alarm.
- key_sel  in  1  debounced key, one-cycle pulse.
- alarm_hit  in  1  one-cycle pulse when time equals alarm.
- t_hourH, t_hourL, t_minH, t_minL  in  4 each  current time, BCD.
- a_hourH, a_hourL, a_minH, a_minL  in  4 each  alarm setting, BCD.
- dig3, dig2, dig1, dig0  out  4 each  BCD digits to the tube decoder; dig3 is hourH and dig0 is minL.
- blank  out  4  per-digit blank mask; bit n = 1 blanks dign.
- adj_field  out  2  field being adjusted: 00 = none, 01 = minutes, 10 = hours.
- adj_tgt  out  1  adjust target: 1 = time, 0 = alarm.
- ring  out  1  alarm buzzer/LED drive, active high.

Function
REQ-004 sw0 and sw1 SHALL each be registered once (sw0_q, sw1_q) before use; all decisions SHALL use only the registered copies.
REQ-005 The FSM SHALL have four states: RUN, RING, ADJ_MIN, ADJ_HOUR, evaluated every clk.
REQ-006 From RUN or RING, sw0_q=0 SHALL move the FSM to ADJ_MIN; this transition takes priority over all other events and cancels any ring.
REQ-007 RUN with alarm_hit=1 and sw0_q=1 SHALL move the FSM to RING.
REQ-008 RING SHALL return to RUN on key_sel=1, or when the ring timer expires (REQ-012).
REQ-009 In ADJ_MIN and ADJ_HOUR:
- sw0_q=1 SHALL move the FSM to RUN.
- Otherwise key_sel=1 SHALL toggle between ADJ_MIN and ADJ_HOUR.
- alarm_hit SHALL be ignored.
REQ-010 Digit source selection:
- RUN, RING: dig3..dig0 SHALL show t_hourH, t_hourL, t_minH, t_minL.
- ADJ_*: the digits SHALL show the time inputs if sw1_q=1, otherwise the alarm inputs.
- Every output SHALL be registered, and digits SHALL reflect input values with 1 clk latency.
REQ-011 Blink generator:
- The counter SHALL count 0..BLINK_HALF-1 on tick_1k pulses.
- On a tick_1k at BLINK_HALF-1 the counter SHALL wrap to 0 and toggle blink_ph.
- On any state change, the counter and blink_ph SHALL both clear to 0 (field visible first).
REQ-012 Ring timer:
- A ms counter (0..999, advancing on tick_1k) and a seconds counter (0..RING_SEC-1) SHALL both clear on RING entry.
- The timer SHALL expire on the tick_1k where ms=999 and sec=RING_SEC-1.
REQ-013 blank output by state:
- RUN: blank=0000.
- ADJ_MIN: blank={2'b00, blink_ph, blink_ph}.
- ADJ_HOUR: blank={blink_ph, blink_ph, 2'b00}.
- RING: blank={4{blink_ph}}.
REQ-014 Status outputs by state:
- ring SHALL be 1 only in RING.
- adj_field SHALL be 01 in ADJ_MIN, 10 in ADJ_HOUR, and 00 otherwise.
- adj_tgt SHALL equal sw1_q in ADJ_* states and 1 otherwise.
REQ-015 Simultaneous events:
- key_sel and alarm_hit in the same RUN cycle: the FSM SHALL enter RING and key_sel SHALL be ignored.
- key_sel on the same cycle as sw0_q falling: the FSM SHALL enter ADJ_MIN.
REQ-016 BCD inputs above 9 SHALL pass through unchanged; this block performs no arithmetic on digit values.

Reset
REQ-017 With rst_n=0 at a clk edge, the block SHALL set:
- State to RUN, with the blink counter, blink_ph, ms and sec counters, sw0_q and sw1_q all cleared to 0.
- dig3..dig0=0, blank=0000, adj_field=00, adj_tgt=1, ring=0.
REQ-018 Reset SHALL override all other inputs, including mid-RING and mid-adjust; reset is not required to be glitch-free on outputs.

Verification
REQ-019 Reset then RUN: rst_n low 2 clk, then high with sw0=1 and time 12:34 -> dig3..0=1,2,3,4; blank=0000; ring=0.
REQ-020 Adjust blink: sw0=0, sw1=1 -> adj_field=01 by clk 2; blank[1:0] goes 00→11 after 250 tick_1k and back to 00 after 500; one key_sel -> adj_field=10, blank restarts at 0000.
REQ-021 Alarm view: sw0=0, sw1=0, alarm 07:05 -> dig=0,7,0,5 and adj_tgt=0; toggling sw1 to 1 -> time digits shown 2 clk later.
REQ-022 Ring timeout: alarm_hit in RUN -> ring=1 next clk; with no key, ring falls exactly 30000 tick_1k after entry; blank all toggles every 250 ticks.
REQ-023 Ring dismiss and priority: alarm_hit and key_sel in the same cycle -> RING; a later key_sel -> RUN; sw0=0 during RING -> ADJ_MIN and ring=0.
REQ-024 Mid-operation reset: rst_n low while in ADJ_HOUR with blink_ph=1 -> all outputs equal the REQ-017 values after one clk.
